exponent_host: RTL and testbench

Initiator-side controller for the exponentiation accelerator: accepts tagged (x, a) jobs over a valid/ready stream, buffers them, issues them one at a time over the accelerator's enable/ready handshake, and returns each tagged result p over a valid/ready stream. It sits between the system command path and the accelerator core and serialises all access to it.

---
 rtl/exp_pkg.sv | 22 ++
 rtl/exp_job_fifo.sv | 50 +++++
 rtl/exponent_host.sv | 163 ++++++++++++++++
 tb/tb_exponent_host.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared types for the exponentiation host: FSM state encoding, default widths and the job payload.
package exp_pkg;

    localparam int unsigned EXP_DATA_W = 32;
    localparam int unsigned EXP_TAG_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BLANK,
        ST_WAIT,
        ST_RESULT,
        ST_DRAIN
    } exp_host_state_t;

    typedef struct packed {
        logic [EXP_DATA_W-1:0] x;
        logic [EXP_DATA_W-1:0] a;
        logic [EXP_TAG_W-1:0]  tag;
    } exp_job_t;

endpackage

// File: rtl/exp_job_fifo.sv
// Synchronous job FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module exp_job_fifo
    import exp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  exp_job_t         push_job,
    input  logic             pop,
    output exp_job_t         head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    exp_job_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CNT_W'(wr_ptr - rd_ptr);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_job;
    end

endmodule

// File: rtl/exponent_host.sv
// exponent_host: buffers tagged (x, a) jobs and serialises them onto the exponentiation accelerator.
// Defining EXP_HOST_TIMEOUT_EN adds a WAIT-state watchdog that returns an error result and drains the core.
module exponent_host
    import exp_pkg::*;
#(
    parameter int unsigned DATA_W         = EXP_DATA_W,
    parameter int unsigned TAG_W          = EXP_TAG_W,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned PEND_W        = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_x,
    input  logic [DATA_W-1:0] job_a,
    input  logic [TAG_W-1:0]  job_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_p,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err,
    output logic              acc_enable,
    output logic [DATA_W-1:0] acc_x,
    output logic [DATA_W-1:0] acc_a,
    input  logic              acc_ready,
    input  logic [DATA_W-1:0] acc_p,
    output logic [PEND_W-1:0] pending
);

    exp_host_state_t   state;
    exp_host_state_t   state_next;
    exp_job_t          in_job;
    exp_job_t          head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PEND_W-1:0] fifo_count;
    logic              push;
    logic              pop;
    logic              capture;
    logic              issue_ok;

    assign in_job    = '{x: EXP_DATA_W'(job_x), a: EXP_DATA_W'(job_a), tag: EXP_TAG_W'(job_tag)};
    assign job_ready = reset_n && !fifo_full;
    assign push      = job_valid && job_ready;
    assign pending   = fifo_count + PEND_W'(state != ST_IDLE);

    exp_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_job (in_job),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

`ifdef EXP_HOST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             expire;
    logic             err_q;

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
`ifdef EXP_HOST_TIMEOUT_EN
        expire     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (issue_ok && acc_ready && !fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_BLANK;
            ST_BLANK: state_next = ST_WAIT;
            ST_WAIT: begin
                if (acc_ready) begin
                    capture    = 1'b1;
                    state_next = ST_RESULT;
                end
`ifdef EXP_HOST_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    expire     = 1'b1;
                    state_next = ST_RESULT;
                end
`endif
            end
            ST_RESULT: begin
                if (res_ready) begin
`ifdef EXP_HOST_TIMEOUT_EN
                    state_next = err_q ? ST_DRAIN : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_DRAIN: begin
                if (acc_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // issue_ok is a registered view of "job waiting and core idle", so a fresh job issues two cycles after acceptance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            issue_ok   <= 1'b0;
            acc_enable <= 1'b0;
            acc_x      <= '0;
            acc_a      <= '0;
            res_valid  <= 1'b0;
            res_p      <= '0;
            res_tag    <= '0;
        end else begin
            state      <= state_next;
            issue_ok   <= !fifo_empty && acc_ready;
            acc_enable <= (state_next == ST_ISSUE);
            res_valid  <= (state_next == ST_RESULT);
            if (pop) begin
                acc_x   <= DATA_W'(head.x);
                acc_a   <= DATA_W'(head.a);
                res_tag <= TAG_W'(head.tag);
            end
            if (capture) res_p <= acc_p;
`ifdef EXP_HOST_TIMEOUT_EN
            if (expire) res_p <= '0;
`endif
        end
    end

`ifdef EXP_HOST_TIMEOUT_EN
    // Watchdog counts WAIT cycles; BLANK always precedes WAIT, so clearing there marks WAIT entry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_BLANK)     tmo_cnt <= '0;
            else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (capture)     err_q <= 1'b0;
            else if (expire) err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_exponent_host.sv
// Directed bench for exponent_host with a behavioural accelerator of programmable latency.
module tb_exponent_host;

    logic        clock;
    logic        reset_n;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_x;
    logic [31:0] job_a;
    logic [3:0]  job_tag;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_p;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        acc_enable;
    logic [31:0] acc_x;
    logic [31:0] acc_a;
    logic        acc_ready;
    logic [31:0] acc_p;
    logic [2:0]  pending;

    int n_checks = 0;
    int n_pass   = 0;
    int en_cnt   = 0;
    int rv_cnt   = 0;
    int viol     = 0;

    exponent_host #(
        .DATA_W         (32),
        .TAG_W          (4),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_x      (job_x),
        .job_a      (job_a),
        .job_tag    (job_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_p      (res_p),
        .res_tag    (res_tag),
        .res_err    (res_err),
        .acc_enable (acc_enable),
        .acc_x      (acc_x),
        .acc_a      (acc_a),
        .acc_ready  (acc_ready),
        .acc_p      (acc_p),
        .pending    (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Accelerator model: drops ready the cycle after enable, raises it with x**a after bfm_lat cycles.
    logic        bfm_rdy;
    logic        bfm_busy;
    logic [31:0] bfm_res;
    logic [31:0] bfm_p;
    int          bfm_cnt;
    int          bfm_lat   = 6;
    bit          bfm_hold  = 1'b0;
    bit          bfm_never = 1'b0;

    assign acc_ready = bfm_rdy && !bfm_hold;
    assign acc_p     = bfm_p;

    function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] a);
        logic [31:0] r = 32'd1;
        for (int i = 0; i < int'(a); i++) r = r * x;
        return r;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            bfm_rdy  <= 1'b1;
            bfm_busy <= 1'b0;
            bfm_p    <= '0;
            bfm_cnt  <= 0;
        end else if (acc_enable) begin
            bfm_rdy  <= 1'b0;
            bfm_busy <= 1'b1;
            bfm_cnt  <= bfm_lat;
            bfm_res  <= pow32(acc_x, acc_a);
        end else if (bfm_busy && !bfm_never) begin
            if (bfm_cnt <= 1) begin
                bfm_rdy  <= 1'b1;
                bfm_busy <= 1'b0;
                bfm_p    <= bfm_res;
            end else begin
                bfm_cnt <= bfm_cnt - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (acc_enable) en_cnt++;
            if (acc_enable && !acc_ready) viol++;
            if (res_valid) rv_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic send_job(input logic [31:0] x, input logic [31:0] a, input logic [3:0] t);
        int n = 0;
        job_x = x; job_a = a; job_tag = t; job_valid = 1'b1;
        while (!job_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("job_accept", job_ready, 1);
        @(negedge clock);
        job_valid = 1'b0;
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!acc_enable && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("enable_wait", acc_enable, 1);
    endtask

    task automatic take_result(input logic [31:0] p, input logic [3:0] t, input logic e);
        int n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("res_valid_wait", res_valid, 1);
        check("res_p", res_p, p);
        check("res_tag", res_tag, t);
        check("res_err", res_err, e);
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        check("res_release", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        int en0;
        int rv0;
        logic [31:0] p0;
        logic [3:0]  t0;

        reset_n = 1'b0; job_valid = 1'b0; job_x = '0; job_a = '0; job_tag = '0; res_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_job_ready", job_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_pending", pending, 0);
        check("rst_acc_enable", acc_enable, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_job_ready", job_ready, 1);

        // Single job 3**4, accepted at edge N; enable expected after edge N+2.
        job_x = 32'd3; job_a = 32'd4; job_tag = 4'd5; job_valid = 1'b1;
        @(negedge clock);
        job_valid = 1'b0;
        check("pending_one", pending, 1);
        check("enable_n0", acc_enable, 0);
        @(negedge clock);
        check("enable_n1", acc_enable, 0);
        @(negedge clock);
        check("enable_n2", acc_enable, 1);
        check("acc_x", acc_x, 3);
        check("acc_a", acc_a, 4);
        @(negedge clock);
        n = 1;
        check("enable_one_cycle", acc_enable, 0);
        while (!res_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("result_latency", n, 8);

        // Hold result with a second job queued: outputs stable, nothing issued.
        send_job(32'd2, 32'd10, 4'd1);
        p0 = res_p; t0 = res_tag; bad = 0; en0 = en_cnt;
        repeat (10) begin
            @(negedge clock);
            if (res_valid !== 1'b1 || res_p !== p0 || res_tag !== t0) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_no_issue", en_cnt - en0, 0);
        take_result(32'd81, 4'd5, 1'b0);
        check("b2b_gap", acc_enable, 0);
        @(negedge clock);
        check("b2b_issue", acc_enable, 1);
        take_result(32'd1024, 4'd1, 1'b0);

        // Five jobs: one in flight plus a full FIFO.
        bfm_lat = 12;
        send_job(32'd2, 32'd3, 4'd0);
        wait_enable();
        send_job(32'd3, 32'd3, 4'd1);
        send_job(32'd5, 32'd2, 4'd2);
        send_job(32'hFFFF_FFFF, 32'd2, 4'd3);
        send_job(32'd2, 32'd31, 4'd4);
        check("full_job_ready", job_ready, 0);
        check("full_pending", pending, 5);
        take_result(32'd8, 4'd0, 1'b0);
        take_result(32'd27, 4'd1, 1'b0);
        take_result(32'd25, 4'd2, 1'b0);
        take_result(32'd1, 4'd3, 1'b0);
        take_result(32'h8000_0000, 4'd4, 1'b0);
        check("drained_pending", pending, 0);

        // Accelerator busy on entry: no issue until ready, then within two cycles.
        bfm_lat = 6;
        bfm_hold = 1'b1;
        send_job(32'd4, 32'd5, 4'd9);
        en0 = en_cnt;
        repeat (10) @(negedge clock);
        check("busy_no_issue", en_cnt - en0, 0);
        check("busy_pending", pending, 1);
        bfm_hold = 1'b0;
        n = 0;
        while (!acc_enable && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("issue_after_ready", n, 2);
        take_result(32'd1024, 4'd9, 1'b0);

        // Reset while waiting with two jobs queued.
        bfm_lat = 30;
        send_job(32'd3, 32'd3, 4'd10);
        wait_enable();
        send_job(32'd1, 32'd1, 4'd11);
        send_job(32'd1, 32'd2, 4'd12);
        repeat (4) @(negedge clock);
        check("pre_rst_pending", pending, 3);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_acc_enable", acc_enable, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_job_ready", job_ready, 0);
        check("mid_rst_acc_x", acc_x, 0);
        check("mid_rst_res_p", res_p, 0);
        check("mid_rst_res_tag", res_tag, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst2_pending", pending, 0);
        check("post_rst2_job_ready", job_ready, 1);
        en0 = en_cnt; rv0 = rv_cnt;
        repeat (60) @(negedge clock);
        check("post_rst2_no_issue", en_cnt - en0, 0);
        check("post_rst2_no_result", rv_cnt - rv0, 0);

`ifdef EXP_HOST_TIMEOUT_EN
        // Accelerator never answers: error result after 16 WAIT cycles, then drain before next issue.
        bfm_lat = 6;
        bfm_never = 1'b1;
        send_job(32'd6, 32'd2, 4'd3);
        wait_enable();
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("tmo_latency", n, 18);
        send_job(32'd9, 32'd2, 4'd7);
        take_result(32'd0, 4'd3, 1'b1);
        en0 = en_cnt;
        repeat (10) @(negedge clock);
        check("drain_no_issue", en_cnt - en0, 0);
        bfm_never = 1'b0;
        take_result(32'd81, 4'd7, 1'b0);
`endif

        check("enable_while_busy", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
